// File: rtl/multi_toggle_gen.sv
// Multi-channel square-wave generator with per-channel programmable high/low
// phase lengths, edge pulses, shadowed configuration and global phase alignment.
//
// phase   | meaning
// --------+---------------------------------------------------
// PH_LOW  | out=0, counting low-phase length (also idle state)
// PH_HIGH | out=1, counting high-phase length
module multi_toggle_gen #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 8,
  parameter int DEF_HALF = 5,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_low,
  input  logic              sync,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] edge_pulse,
  output logic [NUM_CH-1:0] cfg_pending
);

  typedef enum logic {PH_LOW = 1'b0, PH_HIGH = 1'b1} phase_t;

  localparam logic [CNT_W-1:0] DEF_LEN = CNT_W'(DEF_HALF);

  phase_t           phase_q    [NUM_CH];
  phase_t           phase_d    [NUM_CH];
  logic [CNT_W-1:0] cnt_q      [NUM_CH];
  logic [CNT_W-1:0] cnt_d      [NUM_CH];
  logic [CNT_W-1:0] act_high_q [NUM_CH];
  logic [CNT_W-1:0] act_high_d [NUM_CH];
  logic [CNT_W-1:0] act_low_q  [NUM_CH];
  logic [CNT_W-1:0] act_low_d  [NUM_CH];
  logic [CNT_W-1:0] shd_high_q [NUM_CH];
  logic [CNT_W-1:0] shd_high_d [NUM_CH];
  logic [CNT_W-1:0] shd_low_q  [NUM_CH];
  logic [CNT_W-1:0] shd_low_d  [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;

  always_comb begin
    logic             hit;
    logic [CNT_W-1:0] new_high;
    logic [CNT_W-1:0] new_low;
    logic [CNT_W-1:0] len;
    hit      = 1'b0;
    new_high = '0;
    new_low  = '0;
    len      = '0;
    pend_d   = pend_q;
    pulse_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Out-of-range channel numbers match no index, so such writes vanish.
      hit      = cfg_we && (cfg_ch == CH_W'(i));
      new_high = hit ? cfg_high : shd_high_q[i];
      new_low  = hit ? cfg_low  : shd_low_q[i];
      len      = (phase_q[i] == PH_HIGH) ? act_high_q[i] : act_low_q[i];
      if (len == '0) len = CNT_W'(1);

      phase_d[i]    = phase_q[i];
      cnt_d[i]      = cnt_q[i];
      act_high_d[i] = act_high_q[i];
      act_low_d[i]  = act_low_q[i];
      shd_high_d[i] = new_high;
      shd_low_d[i]  = new_low;

      if (sync || !en[i]) begin
        phase_d[i]    = PH_LOW;
        cnt_d[i]      = '0;
        act_high_d[i] = new_high;
        act_low_d[i]  = new_low;
        pend_d[i]     = 1'b0;
        pulse_d[i]    = (phase_q[i] == PH_HIGH);
      end else if (cnt_q[i] == len - CNT_W'(1)) begin
        // Boundary loads the shadow as it stood before this edge's write.
        phase_d[i]    = (phase_q[i] == PH_HIGH) ? PH_LOW : PH_HIGH;
        cnt_d[i]      = '0;
        act_high_d[i] = shd_high_q[i];
        act_low_d[i]  = shd_low_q[i];
        pend_d[i]     = hit;
        pulse_d[i]    = 1'b1;
      end else begin
        cnt_d[i]  = cnt_q[i] + CNT_W'(1);
        pend_d[i] = pend_q[i] | hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        phase_q[i]    <= PH_LOW;
        cnt_q[i]      <= '0;
        act_high_q[i] <= DEF_LEN;
        act_low_q[i]  <= DEF_LEN;
        shd_high_q[i] <= DEF_LEN;
        shd_low_q[i]  <= DEF_LEN;
      end
      pend_q  <= '0;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        phase_q[i]    <= phase_d[i];
        cnt_q[i]      <= cnt_d[i];
        act_high_q[i] <= act_high_d[i];
        act_low_q[i]  <= act_low_d[i];
        shd_high_q[i] <= shd_high_d[i];
        shd_low_q[i]  <= shd_low_d[i];
      end
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < NUM_CH; i++) out[i] = (phase_q[i] == PH_HIGH);
  end

  assign edge_pulse  = pulse_q;
  assign cfg_pending = pend_q;

endmodule

// File: tb/tb_multi_toggle_gen.sv
// Directed bench for multi_toggle_gen: a 4-channel instance for the main
// behaviour and a 3-channel instance to exercise an out-of-range channel write.
module tb_multi_toggle_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] en;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_high;
  logic [7:0] cfg_low;
  logic       sync;
  logic [3:0] out, edge_pulse, cfg_pending;

  logic       we3;
  logic [2:0] en3;
  logic [2:0] out3, pulse3, pend3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multi_toggle_gen #(.NUM_CH(4), .CNT_W(8), .DEF_HALF(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_high(cfg_high), .cfg_low(cfg_low), .sync(sync),
    .out(out), .edge_pulse(edge_pulse), .cfg_pending(cfg_pending)
  );

  multi_toggle_gen #(.NUM_CH(3), .CNT_W(8), .DEF_HALF(5)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .cfg_we(we3), .cfg_ch(cfg_ch),
    .cfg_high(cfg_high), .cfg_low(cfg_low), .sync(1'b0),
    .out(out3), .edge_pulse(pulse3), .cfg_pending(pend3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] e_out, e_pul;
    rst_n = 1'b0; en = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_high = '0; cfg_low = '0; sync = 1'b0; we3 = 1'b0; en3 = '0;
    step(); step();
    chk("rst_out", out, 0);
    chk("rst_pulse", edge_pulse, 0);
    chk("rst_pend", cfg_pending, 0);
    rst_n = 1'b1;

    // out-of-range channel on the 3-channel instance leaves defaults intact
    we3 = 1'b1; cfg_ch = 2'd3; cfg_high = 8'd1; cfg_low = 8'd1;
    step();
    we3 = 1'b0;
    chk("inv_pend", pend3, 0);
    en3 = 3'b111;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("inv_out", out3, (k >= 5) ? 3'b111 : 3'b000);
      chk("inv_pend_run", pend3, 0);
    end
    en3 = '0;

    // defaults on ch0: period 10
    en = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("t1_out", out, (((k / 5) % 2) == 1) ? 4'b0001 : 4'b0000);
      chk("t1_pulse", edge_pulse, ((k % 5) == 0) ? 4'b0001 : 4'b0000);
    end

    // write to disabled ch1 applies immediately
    en = '0; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_high = 8'd2; cfg_low = 8'd3;
    step();
    cfg_we = 1'b0;
    chk("t2_pend_wr", cfg_pending, 0);
    en = 4'b0010;
    for (int k = 1; k <= 10; k++) begin
      step();
      e_out = ((k % 5) >= 3) ? 4'b0010 : 4'b0000;
      e_pul = ((k % 5) == 0 || (k % 5) == 3) ? 4'b0010 : 4'b0000;
      chk("t2_out", out, e_out);
      chk("t2_pulse", edge_pulse, e_pul);
      chk("t2_pend", cfg_pending, 0);
    end

    // write mid-high on running ch0: old length completes first
    en = '0;
    step();
    en = 4'b0001;
    for (int k = 1; k <= 6; k++) step();
    chk("t3_high", out, 4'b0001);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_high = 8'd1; cfg_low = 8'd1;
    step();
    cfg_we = 1'b0;
    chk("t3_pend_set", cfg_pending, 4'b0001);
    chk("t3_out7", out, 4'b0001);
    for (int k = 8; k <= 9; k++) begin
      step();
      chk("t3_out_hold", out, 4'b0001);
      chk("t3_pend_hold", cfg_pending, 4'b0001);
    end
    step();
    chk("t3_fall", out, 4'b0000);
    chk("t3_fall_pulse", edge_pulse, 4'b0001);
    chk("t3_pend_clr", cfg_pending, 0);
    for (int k = 11; k <= 16; k++) begin
      step();
      chk("t3_fast_out", out, ((k % 2) == 1) ? 4'b0001 : 4'b0000);
      chk("t3_fast_pulse", edge_pulse, 4'b0001);
    end

    // zero lengths behave as one
    en = '0; cfg_we = 1'b1; cfg_ch = 2'd2; cfg_high = 8'd0; cfg_low = 8'd0;
    step();
    cfg_we = 1'b0;
    chk("t4_pend", cfg_pending, 0);
    en = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t4_out", out, ((k % 2) == 1) ? 4'b0100 : 4'b0000);
      chk("t4_pulse", edge_pulse, 4'b0100);
    end

    // sync realigns ch0 (1/1) and ch1 (2/3)
    en = '0;
    step();
    en = 4'b0011;
    for (int k = 1; k <= 4; k++) step();
    chk("t5_pre_sync", out, 4'b0010);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("t5_sync_out", out, 4'b0000);
    chk("t5_sync_pulse", edge_pulse, 4'b0010);
    for (int k = 1; k <= 5; k++) begin
      step();
      e_out = '0;
      e_out[0] = ((k % 2) == 1);
      e_out[1] = ((k % 5) >= 3);
      chk("t5_realign", out, e_out);
    end
    en = 4'b0010;
    step();
    chk("t5_dis_out", out, 4'b0000);
    chk("t5_dis_pulse", edge_pulse, 4'b0001);

    // reset mid-phase discards a pending write and restores defaults
    en = '0;
    step();
    en = 4'b1000;
    step(); step();
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_high = 8'd1; cfg_low = 8'd1;
    step();
    cfg_we = 1'b0;
    chk("t6_pend", cfg_pending, 4'b1000);
    rst_n = 1'b0;
    step();
    chk("t6_rst_out", out, 0);
    chk("t6_rst_pulse", edge_pulse, 0);
    chk("t6_rst_pend", cfg_pending, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t6_out", out, (((k / 5) % 2) == 1) ? 4'b1000 : 4'b0000);
      chk("t6_pulse", edge_pulse, ((k % 5) == 0) ? 4'b1000 : 4'b0000);
      chk("t6_pend_run", cfg_pending, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
